am_modulator: RTL and testbench
===============================

// Module: am_modulator
// PURPOSE
//  AM transmitter; counterpart of the AM demodulator chain. Scales a 12-bit signed message, adds a DC carrier
//  level to form the envelope, multiplies it by an internal NCO sine carrier.
//  Output is a 16-bit sample stream with valid; bits [11:0] carry the meaningful value, so it loops straight into the demodulator.
// PARAMETERS
//  PHASE_W   32  phase accumulator width
//  LUT_AW    10  full-cycle sine address bits, taken from phase[PHASE_W-1 -: LUT_AW]
// PORTS
//  i_clk            in   1   clock
//  i_rst_n          in   1   asynchronous active-low reset
//  i_enable         in   1   1 = NCO advances and one output sample is produced this cycle
//  i_phase_inc      in   32  carrier phase increment per enabled cycle
//  i_dc_offset      in   12  unsigned carrier level (typ. 2048)
//  i_mod_index      in   8   unsigned modulation gain, Q0.8
//  i_data           in   12  signed message sample
//  i_data_valid     in   1   message strobe
//  o_data           out  16  modulated sample, sign-extended 12-bit signed
//  o_data_valid     out  1   o_data qualifier
//  o_overmod        out  1   1-cycle pulse: envelope left 0..4095 (macro only, else tied 0)
// BEHAVIOUR
//  Reset (async assert, sync release): phase=0, msg reg=0, env reg=0, pipeline valids=0, o_data=0, o_data_valid=0, o_overmod=0.
//  Message: on i_data_valid, scaled = (i_data * i_mod_index) >>> 8 (arith, 20-bit product, trunc toward -inf).
//   env = i_dc_offset + scaled, 14-bit signed; registered next cycle into env reg (12-bit unsigned, see CONFIGURATION).
//   env reg holds between strobes; strobe and enable in same cycle: new env used by the next multiply, no tearing.
//  NCO: on i_enable, phase <= phase + i_phase_inc, mod 2^PHASE_W wrap.
//   LUT address = phase value before the add; i_enable low: phase holds.
//  Sine: sine_lut, 2-cycle registered latency, 12-bit signed, amplitude 2047.
//   sin(addr 0)=0; sin(quarter)=+2047; sin(half)=0; sin(3 quarter)=-2047.
//  Multiply: prod = env(unsigned, zero-extended) * sin(signed) = 25-bit signed;
//   result = prod >>> 12, 12-bit signed (range +/-2047).
//   o_data = {{4{result[11]}}, result}.
//  Pipeline: stage0 phase reg -> stage1/2 LUT -> stage3 multiply reg -> stage4 output reg.
//   Latency from enabled cycle to o_data_valid is exactly 4 clocks.
//   Valid shift-register of depth 4 tracks i_enable; o_data holds last value when o_data_valid=0.
//  i_enable toggling: each enable produces exactly one valid 4 cycles later; no gaps or duplicates.
//  Reset mid-stream: all in-flight valids discarded immediately; first valid comes 4 clocks after the first post-reset enable.
//  i_phase_inc=0: constant output; legal.
// CONFIGURATION
//  AM_MOD_OVERMOD_CLIP_EN defined:
//   env < 0 -> 0; env > 4095 -> 4095.
//   o_overmod pulses 1 cycle, registered with env update.
//  Not defined: env reg = env[11:0] (wrap); o_overmod constant 0.
// STRUCTURE
//  Package am_mod_pkg: widths (MSG_W=12, OUT_W=16, SIN_W=12, SIN_AMP=2047), pipeline latency LAT=4.
//   Also an env-clamp function, used only under the macro.
//  Sub-module sine_lut: quarter-wave ROM (2^(LUT_AW-2) entries) with quadrant fold/negate, 2 registered stages.
// TESTING
//  1 Carrier only: dc=2048, idx=0, inc=2^28 (period 16), enable held.
//    -> o_data samples 4/8/12 after first valid = +1023/0/-1024 (floor of -1023.5); period 16.
//  2 Full positive message: dc=2048, idx=255, i_data=+2047.
//    -> env=4087, peak o_data=+2042, trough=-2043.
//  3 Overmod: dc=3000, idx=255, i_data=+2047 (env 5039). Macro -> env=4095, peak=+2046, o_overmod pulses once.
//    No macro -> env=943, peak=+471, o_overmod=0.
//  4 Enable gaps: i_enable pattern 1,0,1,1,0 -> o_data_valid same pattern delayed 4 clocks; phase advances 3 steps only.
//  5 Reset mid-stream: pull i_rst_n low with 3 samples in flight.
//    -> o_data_valid=0 and o_data=0 same cycle; first post-reset enabled sample uses phase 0 (o_data=0).
//  6 Message timing: strobe i_data=-2048, idx=128, dc=2048 with enable.
//    -> env=1024; samples entering multiply from the next cycle use env 1024; peak=+511.

Source files
------------

// File: rtl/am_mod_pkg.sv
// Shared widths, pipeline depth and helper functions for the AM modulator.
// Provides the quarter-wave sine generator and the envelope clamp helpers.
package am_mod_pkg;

   localparam int MSG_W   = 12;
   localparam int IDX_W   = 8;
   localparam int OUT_W   = 16;
   localparam int SIN_W   = 12;
   localparam int SIN_AMP = 2047;
   localparam int LAT     = 4;
   localparam int PROD_W  = MSG_W + IDX_W;
   localparam int ENV_W   = 14;
   localparam int MULP_W  = 25;

   localparam logic signed [ENV_W-1:0] ENV_MAX = 14'sd4095;

   // pi in Q30, used to build the quarter-wave table at elaboration
   localparam longint PI_Q30 = 64'sd3373259426;

   // round(SIN_AMP * sin(pi/2 * i/qn)), integer Taylor series in Q30
   function automatic logic [SIN_W-2:0] sin_q(input int i, input int qn);
      longint x;
      longint term;
      longint sum;
      x    = (longint'(i) * PI_Q30) / longint'(2 * qn);
      term = x;
      sum  = x;
      for (int k = 1; k <= 8; k++) begin
         term = (term * x) >>> 30;
         term = (term * x) >>> 30;
         term = -term / longint'((2 * k) * (2 * k + 1));
         sum  = sum + term;
      end
      return (SIN_W-1)'((sum * SIN_AMP + (64'sd1 <<< 29)) >>> 30);
   endfunction

   function automatic logic env_ovf(input logic signed [ENV_W-1:0] e);
      return (e < 0) || (e > ENV_MAX);
   endfunction

   function automatic logic [SIN_W-1:0] env_clamp(
      input logic signed [ENV_W-1:0] e
   );
      logic [SIN_W-1:0] r;
      if (e < 0)
         r = '0;
      else if (e > ENV_MAX)
         r = '1;
      else
         r = SIN_W'(e);
      return r;
   endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-cycle sine from a quarter-wave ROM with quadrant fold and negate.
// Ports: clk, rst_n, addr (LUT_AW bits), sin (signed, 2 registered stages).
module sine_lut
   import am_mod_pkg::*;
#(
   parameter int LUT_AW = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LUT_AW-1:0]       addr,
   output logic signed [SIN_W-1:0] sin
);

   localparam int QA = LUT_AW - 2;
   localparam int QN = 1 << QA;

   logic [SIN_W-2:0] rom [QN];

   for (genvar g = 0; g < QN; g++) begin : g_rom
      assign rom[g] = sin_q(g, QN);
   end

   logic [1:0]       quad;
   logic [QA-1:0]    idx;
   logic [QA-1:0]    fold;
   logic             peak;
   logic [SIN_W-2:0] mag_q;
   logic             neg_q;

   assign quad = addr[LUT_AW-1 -: 2];
   assign idx  = addr[QA-1:0];

   // odd quadrants read mirrored; their first entry is the
   // +/- full-scale peak, which sits just outside the table
   assign fold = quad[0] ? (~idx + 1'b1) : idx;
   assign peak = quad[0] && (idx == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_q <= '0;
         neg_q <= 1'b0;
      end else begin
         mag_q <= peak ? (SIN_W-1)'(SIN_AMP) : rom[fold];
         neg_q <= quad[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sin <= '0;
      else if (neg_q)
         sin <= -$signed({1'b0, mag_q});
      else
         sin <= $signed({1'b0, mag_q});
   end

endmodule

// File: rtl/am_modulator.sv
// AM transmitter: envelope (dc + scaled message) times NCO sine carrier.
// Ports: i_clk, i_rst_n, i_enable, i_phase_inc, i_dc_offset, i_mod_index,
//  i_data, i_data_valid -> o_data (16b sign-ext), o_data_valid, o_overmod.
// Define AM_MOD_OVERMOD_CLIP_EN to clamp the envelope and flag overmod.
module am_modulator
   import am_mod_pkg::*;
#(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 10
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_enable,
   input  logic [PHASE_W-1:0]      i_phase_inc,
   input  logic [SIN_W-1:0]        i_dc_offset,
   input  logic [IDX_W-1:0]        i_mod_index,
   input  logic signed [MSG_W-1:0] i_data,
   input  logic                    i_data_valid,
   output logic [OUT_W-1:0]        o_data,
   output logic                    o_data_valid,
   output logic                    o_overmod
);

   // NCO: the LUT sees the phase before this cycle's step
   logic [PHASE_W-1:0] phase;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         phase <= '0;
      else if (i_enable)
         phase <= phase + i_phase_inc;
   end

   logic signed [SIN_W-1:0] sin_val;

   sine_lut #(
      .LUT_AW (LUT_AW)
   ) u_lut (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .addr  (phase[PHASE_W-1 -: LUT_AW]),
      .sin   (sin_val)
   );

   // envelope = dc + (msg * idx) >>> 8
   logic signed [PROD_W-1:0] data_x;
   logic signed [PROD_W-1:0] idx_x;
   logic signed [PROD_W-1:0] msg_prod;
   logic signed [MSG_W-1:0]  scaled;
   logic signed [ENV_W-1:0]  dc_x;
   logic signed [ENV_W-1:0]  sc_x;
   logic signed [ENV_W-1:0]  env_sum;

   assign data_x   = PROD_W'(i_data);
   assign idx_x    = $signed(PROD_W'(i_mod_index));
   assign msg_prod = data_x * idx_x;
   assign scaled   = MSG_W'(msg_prod >>> 8);
   assign dc_x     = $signed(ENV_W'(i_dc_offset));
   assign sc_x     = ENV_W'(scaled);
   assign env_sum  = dc_x + sc_x;

   logic [SIN_W-1:0] env_q;

`ifdef AM_MOD_OVERMOD_CLIP_EN
   logic ovm_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         env_q <= '0;
         ovm_q <= 1'b0;
      end else begin
         ovm_q <= i_data_valid && env_ovf(env_sum);
         if (i_data_valid)
            env_q <= env_clamp(env_sum);
      end
   end

   assign o_overmod = ovm_q;
`else
   // out-of-range envelopes wrap modulo 4096
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         env_q <= '0;
      else if (i_data_valid)
         env_q <= SIN_W'(env_sum);
   end

   assign o_overmod = 1'b0;
`endif

   // unsigned envelope times signed carrier
   logic signed [SIN_W:0]    env_s;
   logic signed [MULP_W-1:0] mul_prod;
   logic signed [SIN_W-1:0]  mul_q;

   assign env_s    = $signed({1'b0, env_q});
   assign mul_prod = MULP_W'(env_s) * MULP_W'(sin_val);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         mul_q <= '0;
      else
         mul_q <= SIN_W'(mul_prod >>> 12);
   end

   // valid tracks each enabled cycle through the 4 stages
   logic [LAT-1:0] vld;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         vld <= '0;
      else
         vld <= {vld[LAT-2:0], i_enable};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_data <= '0;
      else if (vld[LAT-2])
         o_data <= {{(OUT_W-SIN_W){mul_q[SIN_W-1]}}, mul_q};
   end

   assign o_data_valid = vld[LAT-1];

endmodule

// File: tb/tb_am_modulator.sv
// Self-checking bench for am_modulator: vector table plus scoreboard.
// Ports driven: all DUT inputs; observed: o_data, o_data_valid, o_overmod.
module tb_am_modulator;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               enable = 1'b0;
   logic               data_valid = 1'b0;
   logic [31:0]        inc = '0;
   logic [11:0]        dc = '0;
   logic [7:0]         idx = '0;
   logic signed [11:0] data_in = '0;
   logic [15:0]        o_data;
   logic               o_data_valid;
   logic               o_overmod;

   am_modulator dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_enable     (enable),
      .i_phase_inc  (inc),
      .i_dc_offset  (dc),
      .i_mod_index  (idx),
      .i_data       (data_in),
      .i_data_valid (data_valid),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .o_overmod    (o_overmod)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] addr;
      int         cyc;
   } sb_t;

   typedef struct {
      int dc;
      int idx;
      int data;
      int exp_q;
      int exp_tq;
      int exp_ovm;
   } vec_t;

   sb_t         sb[$];
   vec_t        tbl[6];
   int          env_hist[4096];
   int          env_m = 0;
   int          cyc = 0;
   int          nchk = 0;
   int          nfail = 0;
   int          ovm_cnt = 0;
   int          q_seen = 0;
   int          tq_seen = 0;
   logic [31:0] phase_m = '0;

   sb_t m_r;
   int  m_e;
   int  m_s;
   int  m_x;
   int  m_a;

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sin_ref(input int a);
      real x;
      x = 2047.0 * $sin(2.0 * 3.14159265358979 * a / 1024.0);
      if (x >= 0.0)
         return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   function automatic int model_env(input int d, input int m, input int x);
      int e;
      e = d + ((x * m) >>> 8);
`ifdef AM_MOD_OVERMOD_CLIP_EN
      if (e < 0)
         e = 0;
      else if (e > 4095)
         e = 4095;
`else
      e = e & 4095;
`endif
      return e;
   endfunction

   task automatic step(input logic en, input logic stb, input int d);
      enable     = en;
      data_valid = stb;
      data_in    = 12'(d);
      @(posedge clk);
      cyc++;
      if (stb)
         env_m = model_env(int'(dc), int'(idx), d);
      env_hist[cyc % 4096] = env_m;
      if (en) begin
         sb.push_back('{addr: phase_m[31:22], cyc: cyc});
         phase_m = phase_m + inc;
      end
      #1;
   endtask

   task automatic do_reset();
      enable     = 1'b0;
      data_valid = 1'b0;
      rst_n      = 1'b0;
      #1;
      check("rst_o_data", int'(o_data), 0);
      check("rst_valid", int'(o_data_valid), 0);
      check("rst_overmod", int'(o_overmod), 0);
      sb.delete();
      phase_m = '0;
      env_m   = 0;
      repeat (2) begin
         @(posedge clk);
         cyc++;
         env_hist[cyc % 4096] = 0;
      end
      #1;
      rst_n   = 1'b1;
      ovm_cnt = 0;
   endtask

   // scoreboard: every valid output retires the oldest enabled sample
   always @(negedge clk) begin
      if (o_overmod)
         ovm_cnt++;
      if (rst_n && o_data_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            m_r = sb.pop_front();
            m_e = env_hist[(m_r.cyc + 1) % 4096];
            m_s = sin_ref(int'(m_r.addr));
            m_x = (m_e * m_s) >>> 12;
            m_a = int'($signed(o_data));
            if (m_r.addr[7:0] == 8'd0) begin
               check("sample_exact", m_a, m_x);
            end else begin
               nchk++;
               if (m_a - m_x > 1 || m_x - m_a > 1) begin
                  nfail++;
                  $display("FAIL sample_near addr %0d: got %0d expected %0d +/-1",
                           m_r.addr, m_a, m_x);
               end
            end
            if (m_r.addr == 10'd256)
               q_seen = m_a;
            if (m_r.addr == 10'd768)
               tq_seen = m_a;
         end
      end
   end

   initial begin
      logic [4:0] pat;
      logic [9:0] vobs;
      logic [9:0] vexp;
      logic [3:0] robs;

      tbl[0] = '{2048, 0, 0, 1023, -1024, 0};
      tbl[1] = '{2048, 255, 2047, 2042, -2043, 0};
      tbl[3] = '{2048, 128, -2048, 511, -512, 0};
      tbl[4] = '{1000, 64, -1000, 374, -375, 0};
`ifdef AM_MOD_OVERMOD_CLIP_EN
      tbl[2] = '{3000, 255, 2047, 2046, -2047, 1};
      tbl[5] = '{100, 255, -2048, 0, 0, 1};
`else
      tbl[2] = '{3000, 255, 2047, 471, -472, 0};
      tbl[5] = '{100, 255, -2048, 1077, -1078, 0};
`endif

      #3;
      for (int i = 0; i < 6; i++) begin
         do_reset();
         dc  = 12'(tbl[i].dc);
         idx = 8'(tbl[i].idx);
         inc = 32'h1000_0000;
         q_seen  = -99999;
         tq_seen = -99999;
         step(1'b0, 1'b1, tbl[i].data);
         repeat (24) step(1'b1, 1'b0, 0);
         repeat (6) step(1'b0, 1'b0, 0);
         check($sformatf("v%0d_peak", i), q_seen, tbl[i].exp_q);
         check($sformatf("v%0d_trough", i), tq_seen, tbl[i].exp_tq);
         check($sformatf("v%0d_overmod", i), ovm_cnt, tbl[i].exp_ovm);
      end

      // enable gaps: valid pattern mirrors enable 4 clocks later
      do_reset();
      dc  = 12'd2048;
      idx = 8'd0;
      inc = 32'h4000_0000;
      step(1'b0, 1'b1, 0);
      pat  = 5'b01101;
      vobs = '0;
      for (int j = 0; j < 10; j++) begin
         step((j < 5) ? pat[j] : 1'b0, 1'b0, 0);
         vobs[j] = o_data_valid;
      end
      vexp = 10'(pat) << 3;
      check("gap_valid_pattern", int'(vobs), int'(vexp));
      tq_seen = -99999;
      step(1'b1, 1'b0, 0);
      repeat (5) step(1'b0, 1'b0, 0);
      check("gap_phase_3_steps", tq_seen, -1024);

      // reset with three samples in flight
      do_reset();
      dc  = 12'd2048;
      idx = 8'd0;
      inc = 32'h4000_0000;
      step(1'b0, 1'b1, 0);
      repeat (7) step(1'b1, 1'b0, 0);
      @(negedge clk);
      #1;
      check("pre_rst_data", int'($signed(o_data)), -1024);
      check("pre_rst_inflight", sb.size(), 3);
      do_reset();
      robs = '0;
      for (int j = 0; j < 4; j++) begin
         step(j == 0, 1'b0, 0);
         robs[j] = o_data_valid;
      end
      check("post_rst_latency", int'(robs), 8);
      check("post_rst_phase0", int'(o_data), 0);
      repeat (3) step(1'b0, 1'b0, 0);

      // message update while the carrier runs
      do_reset();
      dc  = 12'd2048;
      idx = 8'd255;
      inc = 32'h2000_0000;
      step(1'b1, 1'b1, 2047);
      repeat (9) step(1'b1, 1'b0, 0);
      idx = 8'd128;
      step(1'b1, 1'b1, -2048);
      q_seen = -99999;
      repeat (15) step(1'b1, 1'b0, 0);
      repeat (6) step(1'b0, 1'b0, 0);
      check("msg_new_env_peak", q_seen, 511);

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
